// File: rtl/joy_source_arbiter_if.sv
// joy_source_arbiter_if: joystick source and granted-output bundle for the per-player arbiter
interface joy_source_arbiter_if;
  logic       db_ena;
  logic [7:0] p1_usb;
  logic [7:0] p1_db;
  logic [7:0] p2_usb;
  logic [7:0] p2_db;
  logic [7:0] p1_out;
  logic [7:0] p2_out;
  logic       p1_sel;
  logic       p2_sel;
  logic       coin_pulse;
  modport master (
    output db_ena, p1_usb, p1_db, p2_usb, p2_db,
    input  p1_out, p2_out, p1_sel, p2_sel, coin_pulse
  );
  modport slave (
    input  db_ena, p1_usb, p1_db, p2_usb, p2_db,
    output p1_out, p2_out, p1_sel, p2_sel, coin_pulse
  );
endinterface

// File: rtl/joy_source_arbiter.sv
// joy_source_arbiter: per-player USB/DB joystick ownership with idle hold window and shaped coin pulse
module joy_source_arbiter #(
  parameter int HOLD_CYC = 12000,
  parameter int COIN_CYC = 600000
) (
  input logic                 clk_sys,
  input logic                 Reset_n,
  joy_source_arbiter_if.slave bus
);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int CW = (COIN_CYC > 1) ? $clog2(COIN_CYC) : 1;
  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT} state_t;
  logic [7:0] w_usb [2];
  logic [7:0] w_db  [2];
  logic [7:0] w_nxt_out [2];
  assign w_usb[0] = bus.p1_usb;
  assign w_usb[1] = bus.p2_usb;
  assign w_db[0]  = bus.p1_db;
  assign w_db[1]  = bus.p2_db;
  for (genvar i = 0; i < 2; i++) begin : g_slot
    logic          r_sel;
    logic [HW-1:0] r_hold;
    logic [7:0]    r_out;
    logic          w_own;
    logic          w_oth;
    logic          w_nxt_sel;
    logic [HW-1:0] w_nxt_hold;
    assign w_own = r_sel ? |w_db[i] : |w_usb[i];
    assign w_oth = r_sel ? |w_usb[i] : |w_db[i];
    assign w_nxt_sel  = !bus.db_ena ? 1'b0 :
                        (w_own || r_hold != '0) ? r_sel :
                        w_oth ? ~r_sel : r_sel;
    assign w_nxt_hold = !bus.db_ena ? '0 :
                        w_own ? HW'(HOLD_CYC) :
                        (r_hold != '0) ? r_hold - HW'(1) :
                        w_oth ? HW'(HOLD_CYC) : r_hold;
    // Output follows the next owner so a handover and its first data land on the same edge
    assign w_nxt_out[i] = w_nxt_sel ? w_db[i] : w_usb[i];
    // Owner, hold window and granted-bit registers for this player
    always_ff @(posedge clk_sys) begin
      if (!Reset_n) begin
        r_sel  <= 1'b0;
        r_hold <= '0;
        r_out  <= '0;
      end else begin
        r_sel  <= w_nxt_sel;
        r_hold <= w_nxt_hold;
        r_out  <= w_nxt_out[i];
      end
    end
  end
  logic          w_coin_any;
  logic          w_coin_nxt;
  logic          r_coin_d;
  logic          r_armed;
  logic          r_pulse;
  logic [CW-1:0] r_cnt;
  state_t        r_state;
  assign w_coin_any = g_slot[0].r_out[7] | g_slot[1].r_out[7];
  assign w_coin_nxt = w_nxt_out[0][7] | w_nxt_out[1][7];
  // Coin shaper; r_armed stays low after reset until coin is seen released, so a coin
  // held through reset cannot fire on the zero-to-one step of the cleared output registers
  always_ff @(posedge clk_sys) begin
    if (!Reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_pulse  <= 1'b0;
      r_coin_d <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_coin_d <= w_coin_any;
      r_armed  <= r_armed | ~w_coin_nxt;
      case (r_state)
        S_IDLE:
          if (w_coin_any && !r_coin_d && r_armed) begin
            r_state <= S_PULSE;
            r_cnt   <= CW'(COIN_CYC - 1);
            r_pulse <= 1'b1;
          end
        S_PULSE:
          if (r_cnt == '0) begin
            r_state <= S_WAIT;
            r_pulse <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        S_WAIT:
          if (!w_coin_any) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign bus.p1_out     = g_slot[0].r_out;
  assign bus.p2_out     = g_slot[1].r_out;
  assign bus.p1_sel     = g_slot[0].r_sel;
  assign bus.p2_sel     = g_slot[1].r_sel;
  assign bus.coin_pulse = r_pulse;
endmodule

// File: tb/tb_joy_source_arbiter.sv
// tb_joy_source_arbiter: directed stimulus with per-cycle expectation queue checked by a separate monitor
module tb_joy_source_arbiter;
  localparam logic [4:0] O1 = 5'h01, O2 = 5'h02, S1 = 5'h04, S2 = 5'h08, CP = 5'h10, ALL = 5'h1f;
  typedef struct {
    string      n;
    logic [4:0] m;
    logic [7:0] o1;
    logic [7:0] o2;
    logic       s1;
    logic       s2;
    logic       cp;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q[$];
  joy_source_arbiter_if bus ();
  joy_source_arbiter #(.HOLD_CYC(4), .COIN_CYC(8)) dut (
    .clk_sys(clk),
    .Reset_n(rst_n),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input string f, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s %s got %h expected %h at %0t", n, f, got, want, $time);
    end
  endtask
  task automatic tick(input string n, input logic [4:0] m, input logic [7:0] o1, input logic [7:0] o2,
                      input logic s1, input logic s2, input logic cp);
    exp_t e;
    e.n = n; e.m = m; e.o1 = o1; e.o2 = o2; e.s1 = s1; e.s2 = s2; e.cp = cp;
    q.push_back(e);
    @(negedge clk);
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      if (e.m[0]) chk(e.n, "p1_out", bus.p1_out, e.o1);
      if (e.m[1]) chk(e.n, "p2_out", bus.p2_out, e.o2);
      if (e.m[2]) chk(e.n, "p1_sel", {7'd0, bus.p1_sel}, {7'd0, e.s1});
      if (e.m[3]) chk(e.n, "p2_sel", {7'd0, bus.p2_sel}, {7'd0, e.s2});
      if (e.m[4]) chk(e.n, "coin_pulse", {7'd0, bus.coin_pulse}, {7'd0, e.cp});
    end
  end
  initial begin
    rst_n = 1'b0;
    bus.db_ena = 1'b1;
    bus.p1_usb = 8'hff; bus.p1_db = 8'hff; bus.p2_usb = 8'hff; bus.p2_db = 8'hff;
    repeat (2) tick("reset", ALL, 8'h00, 8'h00, 0, 0, 0);
    rst_n = 1'b1;
    tick("reset_release", ALL, 8'hff, 8'hff, 0, 0, 0);
    repeat (10) tick("coin_held_from_reset", CP | O1, 8'hff, 8'hff, 0, 0, 0);
    bus.p1_usb = 8'h00; bus.p1_db = 8'h00; bus.p2_usb = 8'h00; bus.p2_db = 8'h00;
    repeat (6) tick("idle_drain", ALL, 8'h00, 8'h00, 0, 0, 0);
    bus.p1_usb = 8'h08; bus.p1_db = 8'h10;
    repeat (3) tick("hold_usb_active", O1 | S1, 8'h08, 8'h00, 0, 0, 0);
    bus.p1_usb = 8'h00;
    repeat (4) tick("hold_window", O1 | S1, 8'h00, 8'h00, 0, 0, 0);
    tick("hold_switch", O1 | S1, 8'h10, 8'h00, 1, 0, 0);
    tick("hold_db_owner", O1 | S1, 8'h10, 8'h00, 1, 0, 0);
    bus.db_ena = 1'b0; bus.p1_usb = 8'h21;
    tick("db_ena_drop", O1 | S1, 8'h21, 8'h00, 0, 0, 0);
    bus.db_ena = 1'b1; bus.p1_usb = 8'h00; bus.p1_db = 8'h00;
    tick("db_ena_restore", O1 | S1, 8'h00, 8'h00, 0, 0, 0);
    bus.p2_usb = 8'h01; bus.p2_db = 8'h02;
    repeat (100) tick("contention", O2 | S2, 8'h00, 8'h01, 0, 0, 0);
    bus.p2_usb = 8'h00; bus.p2_db = 8'h00;
    repeat (6) tick("idle_drain2", ALL, 8'h00, 8'h00, 0, 0, 0);
    bus.p1_usb = 8'h80;
    tick("coin1_rise", O1 | CP, 8'h80, 8'h00, 0, 0, 0);
    repeat (8) tick("coin1_pulse", O1 | CP, 8'h80, 8'h00, 0, 0, 1);
    repeat (21) tick("coin1_held", O1 | CP, 8'h80, 8'h00, 0, 0, 0);
    bus.p1_usb = 8'h00;
    tick("coin1_release", O1 | CP, 8'h00, 8'h00, 0, 0, 0);
    bus.p2_usb = 8'h80;
    tick("coin2_rise", O2 | CP, 8'h00, 8'h80, 0, 0, 0);
    repeat (8) tick("coin2_pulse", O2 | CP, 8'h00, 8'h80, 0, 0, 1);
    repeat (3) tick("coin2_held", O2 | CP, 8'h00, 8'h80, 0, 0, 0);
    bus.p2_usb = 8'h00;
    repeat (3) tick("coin2_release", O2 | CP, 8'h00, 8'h00, 0, 0, 0);
    bus.p1_usb = 8'h80;
    tick("coin3_rise", O1 | CP, 8'h80, 8'h00, 0, 0, 0);
    repeat (3) tick("coin3_pulse", CP, 8'h80, 8'h00, 0, 0, 1);
    rst_n = 1'b0;
    tick("reset_mid_pulse", ALL, 8'h00, 8'h00, 0, 0, 0);
    rst_n = 1'b1;
    tick("coin3_after_reset", O1 | CP, 8'h80, 8'h00, 0, 0, 0);
    repeat (12) tick("coin3_no_retrigger", CP, 8'h80, 8'h00, 0, 0, 0);
    bus.p1_usb = 8'h00;
    repeat (2) tick("coin3_release", O1 | CP, 8'h00, 8'h00, 0, 0, 0);
    bus.p1_usb = 8'h80;
    tick("coin4_rise", O1 | CP, 8'h80, 8'h00, 0, 0, 0);
    repeat (8) tick("coin4_pulse", CP, 8'h80, 8'h00, 0, 0, 1);
    tick("coin4_end", CP, 8'h80, 8'h00, 0, 0, 0);
    @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/joy_source_arbiter.md
# joy_source_arbiter

Per-player input arbiter between USB joystick (hps_io) and UserIO DB9MD/DB15 joystick.
- Each of the two player slots is granted to one source at a time.
- Ownership changes only after the current owner has been idle for a hold window.
- A shaped, non-retriggering coin pulse is produced for the game core.
- Sits between the joystick decoders and the two-level tread converter and game inputs, on `clk_sys` (12 MHz).

## Interface
Parameters:
- `HOLD_CYC`, 12000, idle cycles before ownership may change (1 ms at 12 MHz); must be ≥ 1.
- `COIN_CYC`, 600000, coin pulse length in cycles (50 ms at 12 MHz); must be ≥ 1.

Ports:
- `clk_sys` in 1: system clock; only clock.
- `Reset_n` in 1: synchronous, active-low reset.
- `db_ena` in 1: 1 = DB joystick present; 0 forces both slots to USB.
- `p1_usb` in 8: player-1 USB bits, active high, map [7]coin [6]start2 [5]start1 [4]fire [3]up [2]down [1]left [0]right.
- `p1_db` in 8: player-1 DB bits, same map.
- `p2_usb` in 8: player-2 USB bits, same map.
- `p2_db` in 8: player-2 DB bits, same map.
- `p1_out` out 8: granted player-1 bits, registered.
- `p2_out` out 8: granted player-2 bits, registered.
- `p1_sel` out 1: player-1 owner, 0 = USB, 1 = DB.
- `p2_sel` out 1: player-2 owner, same encoding.
- `coin_pulse` out 1: shaped coin pulse, high for exactly `COIN_CYC` cycles.

## Operation
Per slot (two identical instances): owner register `sel`, hold counter `hold` (width clog2(`HOLD_CYC`+1)).
- "Active" for a source = OR of its 8 bits.
- Each edge, in priority order:
  1. `db_ena`=0: next `sel`=0, `hold`=0.
  2. Owner active: `sel` kept, `hold` ← `HOLD_CYC`.
  3. Owner idle and `hold`≠0: `hold` decrements; `sel` kept.
  4. Owner idle, `hold`=0, other source active: `sel` toggles, `hold` ← `HOLD_CYC`.
  5. Otherwise: no change.
- Both sources active together: owner keeps the slot (rule 2).
- `pN_out` ← bits of the source selected by the *next* `sel` value, so a switch and the data from the new owner appear on the same edge.

Coin shaper FSM on `coin_any` = `p1_out[7]` | `p2_out[7]`, with previous-cycle register `coin_d`.
- IDLE: `coin_any` & ~`coin_d` → PULSE, counter ← `COIN_CYC`-1, `coin_pulse` ← 1.
- PULSE: counter decrements. At 0 → WAIT_REL, `coin_pulse` ← 0.
- WAIT_REL: `coin_any`=0 → IDLE.
- Coin held for any length gives exactly one pulse.
- Coin edges during PULSE or WAIT_REL are ignored.
- Both players' coins rising on the same cycle give one pulse.

Reset (`Reset_n`=0 at an edge), applied regardless of state, including mid-pulse and mid-hold:
- `sel`=0 (both slots), `hold`=0.
- `p1_out`, `p2_out`=0; `p1_sel`, `p2_sel`=0.
- `coin_d`=0, FSM=IDLE, `coin_pulse`=0.

## Timing
- Input to `pN_out` latency: 1 cycle (single register stage).
- `pN_sel` changes on the same edge as the first `pN_out` sample from the new owner.
- Ownership switch: earliest on the edge where the owner has been idle `HOLD_CYC`+1 consecutive sampled cycles after its last activity and the other source is active.
- `db_ena` falling: `sel`=0 and `pN_out`=USB bits on the next edge.
- Coin path:
  - `pN_out[7]` rises on edge E (input high before E).
  - `coin_pulse` rises on edge E+1.
  - `coin_pulse` falls on edge E+1+`COIN_CYC`.
- No combinational input-to-output paths.
- No handshakes; inputs are assumed already synchronous to `clk_sys`.

## Test plan
Benches use `HOLD_CYC`=4 and `COIN_CYC`=8 unless stated.

1. **Reset:** drive `Reset_n`=0 for 2 cycles with all inputs 0xFF and `db_ena`=1 → all outputs 0 during reset. First edge after release: `p1_sel`=0, `p1_out`=0xFF (USB).
2. **Hold window:** `p1_usb`=0x08 for 3 cycles, then 0x00; `p1_db`=0x10 throughout → `p1_sel` stays 0 while USB is active and for 4 idle cycles. Switches to 1 on the 5th idle edge with `p1_out`=0x10 on that same edge.
3. **Contention:** `p2_usb`=0x01 and `p2_db`=0x02 both continuously active → `p2_sel`=0 and `p2_out`=0x01 for 100 cycles.
4. **db_ena drop:** player 1 owned by DB (`p1_sel`=1); drop `db_ena` → next edge `p1_sel`=0 and `p1_out` equals `p1_usb`, even with `hold`≠0.
5. **Coin shaping:** hold `p1_usb[7]` high for 30 cycles → exactly one `coin_pulse`, 8 cycles wide, starting 1 cycle after `p1_out[7]` rises. Release, then raise `p2_usb[7]` on the cycle after release → second 8-cycle pulse.
6. **Reset mid-pulse:** assert `Reset_n`=0 during cycle 3 of a pulse → `coin_pulse`=0 next edge. After release with coin still held, no pulse until coin is released and pressed again.
